// File: rtl/data_unpack_if.sv
// -----------------------------------------------------------------------------
// data_unpack_if
// Purpose : groups the BRAM read-return, flush, pixel handshake and status
//           signals of data_unpack into one bundle.
// Signals : i_rden / i_data      - read enable and returned BRAM word
//           i_flush              - end-of-line flush
//           o_stall              - back-pressure to the read-request stage
//           o_pixel / o_pixel_vld / i_pixel_rdy - unpacked pixel handshake
//           o_err                - sticky error flag
//           dbg_unpack_pix_cnt   - accepted pixel counter
// Modports: slave  - the data_unpack block
//           master - the request stage / consumer side (or a testbench)
// -----------------------------------------------------------------------------
interface data_unpack_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 24,
  parameter int REG_WIDTH   = 32
);
  logic                   i_rden;
  logic [DATA_WIDTH-1:0]  i_data;
  logic                   i_flush;
  logic                   o_stall;
  logic [PIXEL_WIDTH-1:0] o_pixel;
  logic                   o_pixel_vld;
  logic                   i_pixel_rdy;
  logic                   o_err;
  logic [REG_WIDTH-1:0]   dbg_unpack_pix_cnt;

  modport slave (
    input  i_rden, i_data, i_flush, i_pixel_rdy,
    output o_stall, o_pixel, o_pixel_vld, o_err, dbg_unpack_pix_cnt
  );

  modport master (
    output i_rden, i_data, i_flush, i_pixel_rdy,
    input  o_stall, o_pixel, o_pixel_vld, o_err, dbg_unpack_pix_cnt
  );
endinterface

// File: rtl/data_unpack.sv
// -----------------------------------------------------------------------------
// data_unpack
// Purpose : captures BRAM read data, buffers it in a small word FIFO and
//           unpacks each group of 3 packed 32-bit words into 4 24-bit pixels.
//           Drives o_stall so the request stage never overflows the FIFO.
// Ports   : clk  - system clock
//           rst  - asynchronous, active-high reset
//           bus  - data_unpack_if.slave (read return, flush, pixel handshake,
//                  stall, sticky error, debug pixel counter)
// Config  : DATA_UNPACK_CNT_EN - when defined, dbg_unpack_pix_cnt counts
//           accepted pixels; otherwise it is tied to 0.
//
// state | meaning
// S0    | byte phase 0: next pixel = word[23:0]
// S1    | byte phase 1: next pixel = {word[15:0], res[7:0]}
// S2    | byte phase 2: next pixel = {word[7:0], res[15:0]}
// S3    | byte phase 3: next pixel = res[23:0], no word needed
// -----------------------------------------------------------------------------
module data_unpack #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 24,
  parameter int RD_LATENCY  = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3,
  parameter int REG_WIDTH   = 32
) (
  input logic        clk,
  input logic        rst,
  data_unpack_if.slave bus
);

  localparam int CW = FIFO_AW + 2;
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [CW-1:0]      STALL_TH = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  // read-valid pipeline
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY:0]   vld_sh;
  logic [CW-1:0]         inflight;
  logic                  tap;

  // word FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      cnt_q, cnt_d;
  logic                  full, empty, push, do_push, drop, pop;
  logic [DATA_WIDTH-1:0] head;

  // unpack FSM and output register
  state_t                 state_q, state_d;
  logic [23:0]            res_q, res_d;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                   pvld_q, pvld_d;
  logic                   err_q, err_d;
  logic                   avail;

  assign tap    = vld_q[RD_LATENCY-1];
  assign vld_sh = {vld_q, bus.i_rden};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + {{(CW-1){1'b0}}, vld_q[i]};
  end

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign avail = (state_q == S3) || !empty;

  // Words already requested count against the FIFO, so a read issued in the
  // same cycle stall rises still has a slot.
  assign bus.o_stall = (({1'b0, cnt_q} + inflight) >= STALL_TH);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    pix_d   = pix_q;
    pvld_d  = pvld_q;
    pop     = 1'b0;
    if (bus.i_flush) begin
      // Output register keeps its pixel; only the handshake may complete.
      state_d = S0;
      res_d   = '0;
      if (bus.i_pixel_rdy) pvld_d = 1'b0;
    end else if ((!pvld_q || bus.i_pixel_rdy) && avail) begin
      pvld_d = 1'b1;
      case (state_q)
        S0: begin
          pix_d   = head[23:0];
          res_d   = {16'h0, head[31:24]};
          pop     = 1'b1;
          state_d = S1;
        end
        S1: begin
          pix_d   = {head[15:0], res_q[7:0]};
          res_d   = {8'h0, head[31:16]};
          pop     = 1'b1;
          state_d = S2;
        end
        S2: begin
          pix_d   = {head[7:0], res_q[15:0]};
          res_d   = head[31:8];
          pop     = 1'b1;
          state_d = S3;
        end
        default: begin
          pix_d   = res_q;
          res_d   = '0;
          state_d = S0;
        end
      endcase
    end else if (bus.i_pixel_rdy) begin
      pvld_d = 1'b0;
    end
  end

  always_comb begin
    push     = tap && !bus.i_flush;
    drop     = push && full && !pop;
    do_push  = push && !drop;
    vld_d    = bus.i_flush ? '0 : vld_sh[RD_LATENCY-1:0];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
    err_d = err_q || drop ||
            (bus.i_flush && (!empty || (inflight != '0) || (state_q != S0)));
  end

  // Storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S0;
      res_q    <= '0;
      pix_q    <= '0;
      pvld_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      res_q    <= res_d;
      pix_q    <= pix_d;
      pvld_q   <= pvld_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_pixel     = pix_q;
  assign bus.o_pixel_vld = pvld_q;
  assign bus.o_err       = err_q;

`ifdef DATA_UNPACK_CNT_EN
  logic [REG_WIDTH-1:0] pix_cnt_q, pix_cnt_d;

  assign pix_cnt_d = (pvld_q && bus.i_pixel_rdy) ? pix_cnt_q + REG_WIDTH'(1) : pix_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_cnt_q <= '0;
    else     pix_cnt_q <= pix_cnt_d;
  end

  assign bus.dbg_unpack_pix_cnt = pix_cnt_q;
`else
  assign bus.dbg_unpack_pix_cnt = '0;
`endif

endmodule

// File: tb/tb_data_unpack.sv
// -----------------------------------------------------------------------------
// tb_data_unpack
// Purpose : directed self-checking bench for data_unpack.
// -----------------------------------------------------------------------------
module tb_data_unpack;

  logic clk;
  logic rst;
  data_unpack_if bus ();

  data_unpack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with 1-cycle read latency: data for the address presented
  // in cycle t is on i_data during cycle t+1.
  logic [31:0] bram [0:15];
  int unsigned rd_addr;
  always @(posedge clk) bus.i_data <= bram[rd_addr[3:0]];

  int n_cmp = 0;
  int n_err = 0;
  int issued;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef DATA_UNPACK_CNT_EN
    return 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Byte n of the sequential stream is 0x10+n.
  function automatic logic [31:0] seq_word(input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(16 + 4*k);
    b1 = 8'(17 + 4*k);
    b2 = 8'(18 + 4*k);
    b3 = 8'(19 + 4*k);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] seq_pix(input int j);
    logic [7:0] b0, b1, b2;
    b0 = 8'(16 + 3*j);
    b1 = 8'(17 + 3*j);
    b2 = 8'(18 + 3*j);
    return {8'h00, b2, b1, b0};
  endfunction

  // Requires i_pixel_rdy=1: waits for a valid pixel, checks it, then lets
  // the consuming edge pass.
  task automatic wait_pixel(input string tag, input logic [31:0] exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.o_pixel_vld) found = 1'b1;
      else tick();
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk(tag, {8'h00, bus.o_pixel}, exp);
      tick();
    end
  endtask

  task automatic do_reset();
    bus.i_rden      = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_pixel_rdy = 1'b0;
    rd_addr         = 0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) bram[k] = seq_word(k);
    rst = 1'b1;
    do_reset();

    // Reset state
    chk("rst_vld",   {31'd0, bus.o_pixel_vld}, 32'd0);
    chk("rst_pixel", {8'h00, bus.o_pixel},     32'd0);
    chk("rst_stall", {31'd0, bus.o_stall},     32'd0);
    chk("rst_err",   {31'd0, bus.o_err},       32'd0);
    chk("rst_cnt",   bus.dbg_unpack_pix_cnt,   32'd0);

    // Unpack order and first-pixel latency
    bram[0] = 32'h44332211;
    bram[1] = 32'h88776655;
    bram[2] = 32'hCCBBAA99;
    do_reset();
    bus.i_pixel_rdy = 1'b1;
    bus.i_rden = 1'b1; rd_addr = 0; tick();
    rd_addr = 1; tick();
    chk("lat_vld_before", {31'd0, bus.o_pixel_vld}, 32'd0);
    rd_addr = 2; tick();
    bus.i_rden = 1'b0;
    chk("lat_vld_after", {31'd0, bus.o_pixel_vld}, 32'd1);
    wait_pixel("order_p0", 32'h00332211);
    wait_pixel("order_p1", 32'h00665544);
    wait_pixel("order_p2", 32'h00998877);
    wait_pixel("order_p3", 32'h00CCBBAA);
    chk("order_idle", {31'd0, bus.o_pixel_vld}, 32'd0);
    chk("order_cnt",  bus.dbg_unpack_pix_cnt,   cnt_exp(4));
    chk("order_err",  {31'd0, bus.o_err},       32'd0);

    // Back-pressure: issue reads only while not stalled
    for (int k = 0; k < 16; k++) bram[k] = seq_word(k);
    do_reset();
    issued = 0;
    for (int c = 0; c < 30 && !bus.o_stall; c++) begin
      bus.i_rden = 1'b1;
      rd_addr    = issued;
      issued++;
      tick();
    end
    bus.i_rden = 1'b0;
    chk("bp_issued", 32'(issued), 32'd8);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_stall_hold", {31'd0, bus.o_stall},     32'd1);
      chk("bp_pix_stable", {8'h00, bus.o_pixel},     seq_pix(0));
      chk("bp_vld_stable", {31'd0, bus.o_pixel_vld}, 32'd1);
    end
    chk("bp_err", {31'd0, bus.o_err}, 32'd0);
    bus.i_pixel_rdy = 1'b1;
    for (int j = 0; j < 10; j++) wait_pixel("bp_pix", seq_pix(j));
    chk("bp_cnt",     bus.dbg_unpack_pix_cnt, cnt_exp(10));
    chk("bp_unstall", {31'd0, bus.o_stall},   32'd0);
    chk("bp_err_end", {31'd0, bus.o_err},     32'd0);

    // Forced overflow
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus.i_rden = 1'b1;
      rd_addr    = k;
      tick();
    end
    bus.i_rden = 1'b0;
    tick(); tick();
    chk("ovf_full_err",   {31'd0, bus.o_err},   32'd0);
    chk("ovf_full_stall", {31'd0, bus.o_stall}, 32'd1);
    bus.i_rden = 1'b1; rd_addr = 9; tick();
    bus.i_rden = 1'b0;
    tick(); tick();
    chk("ovf_err", {31'd0, bus.o_err}, 32'd1);
    bus.i_pixel_rdy = 1'b1;
    for (int j = 0; j < 12; j++) wait_pixel("ovf_pix", seq_pix(j));
    tick(); tick();
    chk("ovf_no_extra",   {31'd0, bus.o_pixel_vld}, 32'd0);
    chk("ovf_err_sticky", {31'd0, bus.o_err},       32'd1);

    // Flush while in S1
    bram[0] = 32'h44332211;
    bram[1] = 32'h0A0B0C0D;
    do_reset();
    bus.i_pixel_rdy = 1'b1;
    bus.i_rden = 1'b1; rd_addr = 0; tick();
    bus.i_rden = 1'b0;
    wait_pixel("fl_first", 32'h00332211);
    chk("fl_err_before", {31'd0, bus.o_err}, 32'd0);
    bus.i_flush = 1'b1; tick();
    bus.i_flush = 1'b0;
    chk("fl_err_after", {31'd0, bus.o_err}, 32'd1);
    bus.i_rden = 1'b1; rd_addr = 1; tick();
    bus.i_rden = 1'b0;
    wait_pixel("fl_phase0", 32'h000B0C0D);
    chk("fl_idle", {31'd0, bus.o_pixel_vld}, 32'd0);

    // Reset mid-stream: 3 words in FIFO, 1 in flight, 1 pixel held
    for (int k = 0; k < 16; k++) bram[k] = seq_word(k);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.i_rden = 1'b1;
      rd_addr    = k;
      tick();
    end
    bus.i_rden = 1'b0;
    chk("mid_pre_vld", {31'd0, bus.o_pixel_vld}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_vld",   {31'd0, bus.o_pixel_vld}, 32'd0);
    chk("mid_pixel", {8'h00, bus.o_pixel},     32'd0);
    chk("mid_stall", {31'd0, bus.o_stall},     32'd0);
    chk("mid_err",   {31'd0, bus.o_err},       32'd0);
    chk("mid_cnt",   bus.dbg_unpack_pix_cnt,   32'd0);
    #1;
    rst = 1'b0;
    bus.i_pixel_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("mid_no_pixel", {31'd0, bus.o_pixel_vld}, 32'd0);
    end
    chk("mid_cnt_end", bus.dbg_unpack_pix_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
